// File: rtl/vscale_htif_host_poller_pkg.sv
// Constants and FSM encoding shared by the HTIF host-side tohost poller.
package vscale_htif_host_poller_pkg;
   localparam int          HTIF_PCR_WIDTH   = 64;
   localparam logic [11:0] CSR_ADDR_TO_HOST = 12'h780;
   localparam int          STATE_WIDTH      = 3;

   typedef enum logic [STATE_WIDTH-1:0] {
      ST_IDLE     = 3'd0,
      ST_RD_REQ   = 3'd1,
      ST_RD_RESP  = 3'd2,
      ST_CLR_REQ  = 3'd3,
      ST_CLR_RESP = 3'd4,
      ST_GAP      = 3'd5,
      ST_DONE     = 3'd6
   } poll_state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/vscale_htif_host_poller.sv
// Host-side HTIF master: polls tohost over the PCR port, optionally clears it,
// and reports sticky pass/fail/timeout status.
//
// state     | meaning
// IDLE      | waiting for enable
// RD_REQ    | PCR read of tohost offered
// RD_RESP   | waiting for read data
// CLR_REQ   | PCR write of 0 to tohost offered
// CLR_RESP  | waiting for write acknowledge
// GAP       | idle spacing between zero-result reads
// DONE      | result or timeout captured; absorbing until reset
module vscale_htif_host_poller
   import vscale_htif_host_poller_pkg::*;
#(
   parameter logic [HTIF_PCR_WIDTH-1:0] PASS_VALUE    = 64'd1,
   parameter logic [63:0]               MAX_CYCLES    = 64'd0,
   parameter logic [15:0]               POLL_GAP      = 16'd4,
   parameter logic                      CLEAR_ON_READ = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   output logic                      htif_pcr_req_valid,
   input  logic                      htif_pcr_req_ready,
   output logic                      htif_pcr_req_rw,
   output logic [11:0]               htif_pcr_req_addr,
   output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
   input  logic                      htif_pcr_resp_valid,
   output logic                      htif_pcr_resp_ready,
   input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data,
   output logic                      done,
   output logic                      pass,
   output logic                      fail,
   output logic                      timeout,
   output logic [HTIF_PCR_WIDTH-1:0] fail_code,
   output logic [63:0]               cycle_count,
   output logic [31:0]               poll_count
);

   poll_state_e               state_q, state_d;
   logic [15:0]               gap_q, gap_d;
   logic [HTIF_PCR_WIDTH-1:0] tohost_q, tohost_d;
   logic                      done_q, done_d;
   logic                      pass_q, pass_d;
   logic                      fail_q, fail_d;
   logic                      timeout_q, timeout_d;
   logic [HTIF_PCR_WIDTH-1:0] fail_code_q, fail_code_d;
   logic [63:0]               cycle_q, cycle_d;
   logic [31:0]               poll_q, poll_d;

   logic                      active;
   logic                      expire;
   logic                      eval;
   logic [HTIF_PCR_WIDTH-1:0] eval_val;

   assign htif_pcr_req_valid  = (state_q == ST_RD_REQ) || (state_q == ST_CLR_REQ);
   assign htif_pcr_req_rw     = (state_q == ST_CLR_REQ);
   assign htif_pcr_resp_ready = (state_q == ST_RD_RESP) || (state_q == ST_CLR_RESP);
   assign htif_pcr_req_addr   = CSR_ADDR_TO_HOST;
   assign htif_pcr_req_data   = '0;

   assign active = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign expire = active && (MAX_CYCLES != 64'd0) && (cycle_q == MAX_CYCLES - 64'd1);

   always_comb begin
      state_d     = state_q;
      gap_d       = gap_q;
      tohost_d    = tohost_q;
      done_d      = done_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      timeout_d   = timeout_q;
      fail_code_d = fail_code_q;
      cycle_d     = cycle_q;
      poll_d      = poll_q;
      eval        = 1'b0;
      eval_val    = tohost_q;

      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_RD_REQ;
         end
         ST_RD_REQ: begin
            if (htif_pcr_req_ready) state_d = ST_RD_RESP;
         end
         ST_RD_RESP: begin
            if (htif_pcr_resp_valid) begin
               poll_d = sat_inc32(poll_q);
               if (htif_pcr_resp_data == '0) begin
                  gap_d   = POLL_GAP;
                  state_d = (POLL_GAP == 16'd0) ? ST_RD_REQ : ST_GAP;
               end else begin
                  tohost_d = htif_pcr_resp_data;
                  if (CLEAR_ON_READ) begin
                     state_d = ST_CLR_REQ;
                  end else begin
                     eval     = 1'b1;
                     eval_val = htif_pcr_resp_data;
                  end
               end
            end
         end
         ST_CLR_REQ: begin
            if (htif_pcr_req_ready) state_d = ST_CLR_RESP;
         end
         ST_CLR_RESP: begin
            if (htif_pcr_resp_valid) eval = 1'b1;
         end
         ST_GAP: begin
            gap_d = gap_q - 16'd1;
            if (gap_q <= 16'd1) state_d = ST_RD_REQ;
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A completing evaluation outranks a timeout landing on the same cycle.
      if (eval) begin
         state_d = ST_DONE;
         done_d  = 1'b1;
         if (eval_val == PASS_VALUE) begin
            pass_d = 1'b1;
         end else begin
            fail_d      = 1'b1;
            fail_code_d = eval_val >> 1;
         end
      end else if (expire) begin
         state_d     = ST_DONE;
         done_d      = 1'b1;
         timeout_d   = 1'b1;
         fail_d      = 1'b1;
         fail_code_d = '0;
      end

      if (active && (state_d != ST_DONE)) cycle_d = cycle_q + 64'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         gap_q       <= '0;
         tohost_q    <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
         fail_code_q <= '0;
         cycle_q     <= '0;
         poll_q      <= '0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         tohost_q    <= tohost_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         timeout_q   <= timeout_d;
         fail_code_q <= fail_code_d;
         cycle_q     <= cycle_d;
         poll_q      <= poll_d;
      end
   end

   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = timeout_q;
   assign fail_code   = fail_code_q;
   assign cycle_count = cycle_q;
   assign poll_count  = poll_q;

endmodule

// File: tb/tb_vscale_htif_host_poller.sv
// Bench for vscale_htif_host_poller: behavioural PCR slave with a tohost
// sequence, request and result scoreboards, and one task per scenario.
module tb_vscale_htif_host_poller;
   import vscale_htif_host_poller_pkg::*;

   localparam logic [63:0] MAX_CYC  = 64'd50;
   localparam logic [63:0] PASS_VAL = 64'd1;

   logic        clk = 1'b0;
   logic        reset_n, enable;
   logic        req_valid, req_ready, req_rw;
   logic [11:0] req_addr;
   logic [63:0] req_data;
   logic        resp_valid, resp_ready;
   logic [63:0] resp_data;
   logic        done, pass, fail, timeout;
   logic [63:0] fail_code, cycle_count;
   logic [31:0] poll_count;

   always #5 clk = ~clk;

   vscale_htif_host_poller #(
      .PASS_VALUE   (PASS_VAL),
      .MAX_CYCLES   (MAX_CYC),
      .POLL_GAP     (16'd4),
      .CLEAR_ON_READ(1'b1)
   ) u_dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .enable             (enable),
      .htif_pcr_req_valid (req_valid),
      .htif_pcr_req_ready (req_ready),
      .htif_pcr_req_rw    (req_rw),
      .htif_pcr_req_addr  (req_addr),
      .htif_pcr_req_data  (req_data),
      .htif_pcr_resp_valid(resp_valid),
      .htif_pcr_resp_ready(resp_ready),
      .htif_pcr_resp_data (resp_data),
      .done               (done),
      .pass               (pass),
      .fail               (fail),
      .timeout            (timeout),
      .fail_code          (fail_code),
      .cycle_count        (cycle_count),
      .poll_count         (poll_count)
   );

   typedef struct packed {
      logic        pass;
      logic        fail;
      logic        timeout;
      logic [63:0] code;
      logic        chk_poll;
      logic [31:0] polls;
   } exp_res_t;

   int          n_run  = 0;
   int          n_fail = 0;
   logic        exp_req_q[$];
   exp_res_t    exp_res_q[$];
   logic [63:0] tohost_q[$];
   logic        req_chk;
   int          ready_delay, resp_delay;
   logic        hold_wr, release_wr;

   // PCR slave plus result monitor; everything is driven and sampled on negedge.
   task automatic slave_model();
      logic        s_rv = 1'b0, s_rw = 1'b0, s_rr = 1'b0, s_done = 1'b0;
      logic [11:0] s_addr = '0;
      logic [63:0] s_data = '0;
      int          rdy_cnt = 0, pend_cnt = 0;
      logic        pend = 1'b0, pend_wr = 1'b0;
      logic [63:0] pend_data = '0;
      logic        er_rw;
      exp_res_t    er;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
            pend = 1'b0; s_rv = 1'b0; s_rr = 1'b0; s_done = 1'b0;
            rdy_cnt = ready_delay;
         end else begin
            if (resp_valid && s_rr) begin
               resp_valid = 1'b0; resp_data = '0; pend = 1'b0;
            end
            if (s_rv && req_ready) begin
               if (req_chk) begin
                  n_run++;
                  if (exp_req_q.size() == 0) begin
                     n_fail++;
                     $display("FAIL req_unexpected: got rw=%0b, expected no request", s_rw);
                  end else begin
                     er_rw = exp_req_q.pop_front();
                     if ({s_rw, s_addr, s_data} !== {er_rw, CSR_ADDR_TO_HOST, 64'd0}) begin
                        n_fail++;
                        $display("FAIL req_fields: got rw=%0b addr=%h data=%h, expected rw=%0b addr=%h data=0",
                                 s_rw, s_addr, s_data, er_rw, CSR_ADDR_TO_HOST);
                     end
                  end
               end
               pend = 1'b1; pend_wr = s_rw; pend_cnt = resp_delay; pend_data = '0;
               if (!s_rw && tohost_q.size() > 0) pend_data = tohost_q.pop_front();
               rdy_cnt = ready_delay;
            end
            if (done && !s_done) begin
               if (exp_res_q.size() == 0) begin
                  n_run++; n_fail++;
                  $display("FAIL res_unexpected: done rose, expected no result");
               end else begin
                  er = exp_res_q.pop_front();
                  n_run++;
                  if (pass !== er.pass) begin
                     n_fail++; $display("FAIL res_pass: got %0b, expected %0b", pass, er.pass);
                  end
                  n_run++;
                  if (fail !== er.fail) begin
                     n_fail++; $display("FAIL res_fail: got %0b, expected %0b", fail, er.fail);
                  end
                  n_run++;
                  if (timeout !== er.timeout) begin
                     n_fail++; $display("FAIL res_timeout: got %0b, expected %0b", timeout, er.timeout);
                  end
                  n_run++;
                  if (fail_code !== er.code) begin
                     n_fail++; $display("FAIL res_fail_code: got %h, expected %h", fail_code, er.code);
                  end
                  if (er.chk_poll) begin
                     n_run++;
                     if (poll_count !== er.polls) begin
                        n_fail++; $display("FAIL res_poll_count: got %0d, expected %0d", poll_count, er.polls);
                     end
                  end
               end
            end
            s_done = done; s_rv = req_valid; s_rw = req_rw; s_addr = req_addr;
            s_data = req_data; s_rr = resp_ready;
            req_ready = 1'b0;
            if (s_rv) begin
               if (rdy_cnt > 0) rdy_cnt--;
               else req_ready = 1'b1;
            end
            if (pend && !resp_valid) begin
               if (pend_cnt > 0) pend_cnt--;
               else if (!pend_wr || !hold_wr || release_wr) begin
                  resp_valid = 1'b1; resp_data = pend_data;
               end
            end
         end
      end
   endtask

   task automatic do_reset();
      enable = 1'b0; reset_n = 1'b0; release_wr = 1'b0;
      exp_req_q.delete(); exp_res_q.delete(); tohost_q.delete();
      repeat (2) @(negedge clk);
      @(posedge clk); #2 reset_n = 1'b1;
   endtask

   task automatic kick();
      @(negedge clk); enable = 1'b1;
      @(negedge clk); enable = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      n_run++;
      if ({req_valid, resp_ready, req_rw, done, pass, fail, timeout} !== 7'b0) begin
         n_fail++;
         $display("FAIL rst_flags: got %b, expected 0000000",
                  {req_valid, resp_ready, req_rw, done, pass, fail, timeout});
      end
      n_run++;
      if ({fail_code, cycle_count, poll_count} !== 160'd0) begin
         n_fail++;
         $display("FAIL rst_counters: got code=%h cyc=%0d polls=%0d, expected all 0",
                  fail_code, cycle_count, poll_count);
      end
      n_run++;
      if (req_addr !== CSR_ADDR_TO_HOST || req_data !== 64'd0) begin
         n_fail++;
         $display("FAIL rst_addr_data: got addr=%h data=%h, expected %h/0", req_addr, req_data, CSR_ADDR_TO_HOST);
      end
      repeat (2) @(negedge clk);
      @(posedge clk); #2 reset_n = 1'b1;
      repeat (5) @(negedge clk);
      n_run++;
      if (req_valid !== 1'b0 || cycle_count !== 64'd0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: got req_valid=%0b cyc=%0d done=%0b, expected 0/0/0", req_valid, cycle_count, done);
      end
   endtask

   task automatic test_pass_after_zeros();
      exp_res_t e;
      logic [63:0] cyc_frozen;
      do_reset();
      tohost_q = '{64'd0, 64'd0, 64'd0, 64'd1};
      exp_req_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      e = '0; e.pass = 1'b1; e.chk_poll = 1'b1; e.polls = 32'd4;
      exp_res_q.push_back(e);
      @(negedge clk); enable = 1'b1;
      @(posedge clk); #1;
      n_run++;
      if (req_valid !== 1'b1 || req_rw !== 1'b0) begin
         n_fail++; $display("FAIL t1_issue_latency: got valid=%0b rw=%0b, expected 1/0", req_valid, req_rw);
      end
      @(negedge clk); enable = 1'b0;
      for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge clk);
      n_run++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL t1_done_wait: got done=%0b, expected 1 within 200 cycles", done);
      end
      @(negedge clk);
      n_run++;
      if (exp_req_q.size() != 0 || exp_res_q.size() != 0) begin
         n_fail++;
         $display("FAIL t1_sb_drain: got %0d reqs %0d results left, expected 0/0", exp_req_q.size(), exp_res_q.size());
      end
      cyc_frozen = cycle_count;
      enable = 1'b1;
      repeat (4) @(negedge clk);
      enable = 1'b0;
      n_run++;
      if (req_valid !== 1'b0 || done !== 1'b1 || cycle_count !== cyc_frozen) begin
         n_fail++;
         $display("FAIL t1_done_absorb: got valid=%0b done=%0b cyc=%0d, expected 0/1/%0d",
                  req_valid, done, cycle_count, cyc_frozen);
      end
   endtask

   task automatic test_fail_code();
      exp_res_t e;
      do_reset();
      tohost_q = '{64'h2B};
      exp_req_q = '{1'b0, 1'b1};
      e = '0; e.fail = 1'b1; e.code = 64'h15; e.chk_poll = 1'b1; e.polls = 32'd1;
      exp_res_q.push_back(e);
      kick();
      for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
      n_run++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL t2_done_wait: got done=%0b, expected 1 within 100 cycles", done);
      end
      @(negedge clk);
      n_run++;
      if (exp_req_q.size() != 0 || exp_res_q.size() != 0) begin
         n_fail++;
         $display("FAIL t2_sb_drain: got %0d reqs %0d results left, expected 0/0", exp_req_q.size(), exp_res_q.size());
      end
   endtask

   task automatic test_timeout();
      exp_res_t e;
      req_chk = 1'b0;
      do_reset();
      e = '0; e.fail = 1'b1; e.timeout = 1'b1;
      exp_res_q.push_back(e);
      kick();
      for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
      n_run++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL t3_done_wait: got done=%0b, expected 1 within 100 cycles", done);
      end
      n_run++;
      if (cycle_count !== 64'd49) begin
         n_fail++; $display("FAIL t3_cycle_count: got %0d, expected 49", cycle_count);
      end
      n_run++;
      if (req_valid !== 1'b0 || resp_ready !== 1'b0) begin
         n_fail++; $display("FAIL t3_handshake_drop: got valid=%0b resp_ready=%0b, expected 0/0", req_valid, resp_ready);
      end
      @(negedge clk);
      n_run++;
      if (exp_res_q.size() != 0) begin
         n_fail++; $display("FAIL t3_sb_drain: got %0d results left, expected 0", exp_res_q.size());
      end
      req_chk = 1'b1;
   endtask

   task automatic test_ready_stall();
      exp_res_t e;
      ready_delay = 10;
      do_reset();
      tohost_q = '{64'd1};
      exp_req_q = '{1'b0, 1'b1};
      e = '0; e.pass = 1'b1; e.chk_poll = 1'b1; e.polls = 32'd1;
      exp_res_q.push_back(e);
      kick();
      for (int i = 0; i < 20 && req_valid !== 1'b1; i++) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         n_run++;
         if (req_valid !== 1'b1 || req_rw !== 1'b0 || req_addr !== CSR_ADDR_TO_HOST || req_data !== 64'd0) begin
            n_fail++;
            $display("FAIL t4_req_stable[%0d]: got valid=%0b rw=%0b addr=%h data=%h, expected 1/0/%h/0",
                     k, req_valid, req_rw, req_addr, req_data, CSR_ADDR_TO_HOST);
         end
         n_run++;
         if (poll_count !== 32'd0) begin
            n_fail++; $display("FAIL t4_poll_during_stall[%0d]: got %0d, expected 0", k, poll_count);
         end
         @(negedge clk);
      end
      for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
      n_run++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL t4_done_wait: got done=%0b, expected 1 within 100 cycles", done);
      end
      @(negedge clk);
      n_run++;
      if (exp_req_q.size() != 0 || exp_res_q.size() != 0) begin
         n_fail++;
         $display("FAIL t4_sb_drain: got %0d reqs %0d results left, expected 0/0", exp_req_q.size(), exp_res_q.size());
      end
      ready_delay = 0;
   endtask

   task automatic test_reset_mid_resp();
      exp_res_t e;
      resp_delay = 20;
      do_reset();
      tohost_q = '{64'h7, 64'd1};
      exp_req_q = '{1'b0};
      kick();
      for (int i = 0; i < 20 && resp_ready !== 1'b1; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      n_run++;
      if (resp_ready !== 1'b1 || poll_count !== 32'd0) begin
         n_fail++; $display("FAIL t5_in_rd_resp: got resp_ready=%0b polls=%0d, expected 1/0", resp_ready, poll_count);
      end
      #2 reset_n = 1'b0;
      #1;
      n_run++;
      if ({req_valid, resp_ready, req_rw, done, pass, fail, timeout} !== 7'b0 ||
          {fail_code, cycle_count, poll_count} !== 160'd0) begin
         n_fail++;
         $display("FAIL t5_async_clear: got flags=%b code=%h cyc=%0d polls=%0d, expected all 0",
                  {req_valid, resp_ready, req_rw, done, pass, fail, timeout}, fail_code, cycle_count, poll_count);
      end
      n_run++;
      if (exp_req_q.size() != 0) begin
         n_fail++; $display("FAIL t5_first_read: got %0d reqs left, expected 0", exp_req_q.size());
      end
      repeat (2) @(negedge clk);
      resp_delay = 0;
      @(posedge clk); #2 reset_n = 1'b1;
      exp_req_q = '{1'b0, 1'b1};
      e = '0; e.pass = 1'b1; e.chk_poll = 1'b1; e.polls = 32'd1;
      exp_res_q.push_back(e);
      kick();
      for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
      n_run++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL t5_done_wait: got done=%0b, expected 1 within 100 cycles", done);
      end
      @(negedge clk);
      n_run++;
      if (exp_req_q.size() != 0 || exp_res_q.size() != 0) begin
         n_fail++;
         $display("FAIL t5_sb_drain: got %0d reqs %0d results left, expected 0/0", exp_req_q.size(), exp_res_q.size());
      end
   endtask

   task automatic test_eval_vs_timeout();
      exp_res_t e;
      hold_wr = 1'b1;
      do_reset();
      tohost_q = '{64'd1};
      exp_req_q = '{1'b0, 1'b1};
      e = '0; e.pass = 1'b1; e.chk_poll = 1'b1; e.polls = 32'd1;
      exp_res_q.push_back(e);
      kick();
      for (int i = 0; i < 100 && cycle_count !== 64'd49; i++) begin
         @(posedge clk); #1;
      end
      n_run++;
      if (cycle_count !== 64'd49 || resp_ready !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL t6_pre_collision: got cyc=%0d resp_ready=%0b done=%0b, expected 49/1/0",
                  cycle_count, resp_ready, done);
      end
      release_wr = 1'b1;
      for (int i = 0; i < 10 && done !== 1'b1; i++) @(negedge clk);
      n_run++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL t6_done_wait: got done=%0b, expected 1 within 10 cycles", done);
      end
      @(negedge clk);
      n_run++;
      if (timeout !== 1'b0 || cycle_count !== 64'd49) begin
         n_fail++; $display("FAIL t6_eval_wins: got timeout=%0b cyc=%0d, expected 0/49", timeout, cycle_count);
      end
      n_run++;
      if (exp_req_q.size() != 0 || exp_res_q.size() != 0) begin
         n_fail++;
         $display("FAIL t6_sb_drain: got %0d reqs %0d results left, expected 0/0", exp_req_q.size(), exp_res_q.size());
      end
      hold_wr = 1'b0;
      release_wr = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b0;
      req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
      req_chk = 1'b1; ready_delay = 0; resp_delay = 0;
      hold_wr = 1'b0; release_wr = 1'b0;
      fork
         slave_model();
      join_none
      test_reset();
      test_pass_after_zeros();
      test_fail_code();
      test_timeout();
      test_ready_stall();
      test_reset_mid_resp();
      test_eval_vs_timeout();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
